// File: rtl/inverter_arbiter_if.sv
// Request and response channels between the
// client blocks and the shared inverter.
interface inverter_arbiter_if #(
  parameter int WIDTH = 8
) ();
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_data;
  logic [3:0]         req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [WIDTH-1:0]   rsp_data;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_id,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output rsp_valid,
    input  rsp_ready,
    output rsp_id,
    output rsp_data
  );
endinterface

// File: rtl/inverter_arbiter.sv
// Round-robin arbiter sharing one registered
// inverter between four requesters.
module inverter_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  inverter_arbiter_if.slave   bus,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [1:0]         ptr;
  logic [1:0]         win;
  logic [1:0]         idx;
  logic               found;
  logic [3:0]         grant;
  logic               xfer;
  logic [WIDTH-1:0]   op;
  logic [1:0]         id;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [1:0]         rsp_id_q;
  logic [WIDTH-1:0]   slice;

  // Search upward from ptr; first pending request wins.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && !reset && found)
      grant[win] = 1'b1;
  end

  assign xfer  = |(bus.req_valid & grant);
  assign slice = bus.req_data[win*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (xfer) state_n = EVAL;
      EVAL: state_n = RESP;
      RESP: if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      op         <= '0;
      id         <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      if (xfer) begin
        op  <= slice;
        id  <= win;
        ptr <= win + 2'd1;
      end
      if (state == EVAL) begin
        rsp_data_q <= ~op;
        rsp_id_q   <= id;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_inverter_arbiter.sv
// Bench for inverter_arbiter: vector table,
// scoreboard monitor and corner sequences.
module tb_inverter_arbiter;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        rr;
    logic [3:0]  e_ready;
    logic        e_valid;
    logic        e_busy;
    logic [7:0]  e_data;
    logic [1:0]  e_id;
    logic        chk_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  inverter_arbiter_if #(.WIDTH(8)) bus ();

  inverter_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   m_state = 0;
  int   m_ptr = 0;
  logic [7:0] m_data = '0;
  logic [1:0] m_id = '0;
  sb_t  sb[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Reference model: grant prediction plus response scoreboard.
  always @(negedge clk) begin : mon
    logic [3:0] er;
    int w;
    sb_t it;
    if (mon_en) begin
      er = '0;
      w = -1;
      if (!reset && m_state == 0)
        for (int k = 0; k < 4; k++)
          if (w < 0 && bus.req_valid[(m_ptr + k) % 4])
            w = (m_ptr + k) % 4;
      if (w >= 0) er[w] = 1'b1;
      chk("mon_req_ready", 32'(bus.req_ready), 32'(er));
      chk("mon_rsp_valid", 32'(bus.rsp_valid),
          32'(m_state == 2));
      chk("mon_busy", 32'(busy), 32'(m_state != 0));
      if (m_state == 2) begin
        chk("mon_sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
          chk("mon_rsp_data", 32'(bus.rsp_data),
              32'(sb[0].data));
          chk("mon_rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
        end
      end else begin
        chk("mon_hold_data", 32'(bus.rsp_data), 32'(m_data));
        chk("mon_hold_id", 32'(bus.rsp_id), 32'(m_id));
      end
      if (reset) begin
        m_state = 0;
        m_ptr = 0;
        m_data = '0;
        m_id = '0;
        sb.delete();
      end else begin
        case (m_state)
          0: if (w >= 0) begin
            it.id = 2'(w);
            it.data = ~bus.req_data[w*8 +: 8];
            sb.push_back(it);
            m_ptr = (w + 1) % 4;
            m_state = 1;
          end
          1: m_state = 2;
          default: if (bus.rsp_ready) begin
            if (sb.size() > 0) begin
              it = sb.pop_front();
              m_data = it.data;
              m_id = it.id;
            end
            m_state = 0;
          end
        endcase
      end
    end
  end

  vec_t tv[20];
  logic [7:0] rsp_exp[5];
  logic [3:0] gnt_exp[5];

  initial begin
    rsp_exp = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'hFF};
    gnt_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      tv[i].rst = (i < 2);
      tv[i].rv = '0;
      tv[i].rd = '0;
      tv[i].rr = 1'b0;
      tv[i].e_ready = '0;
      tv[i].e_valid = 1'b0;
      tv[i].e_busy = 1'b0;
      tv[i].e_data = '0;
      tv[i].e_id = '0;
      tv[i].chk_data = 1'b1;
    end
    for (int k = 0; k < 15; k++) begin
      tv[5+k].rst = 1'b0;
      tv[5+k].rv = 4'b1111;
      tv[5+k].rd = 32'hF00FFF00;
      tv[5+k].rr = 1'b1;
      tv[5+k].e_ready = (k % 3 == 0) ? gnt_exp[k/3] : 4'b0000;
      tv[5+k].e_valid = (k % 3 == 2);
      tv[5+k].e_busy = (k % 3 != 0);
      tv[5+k].e_data = rsp_exp[k/3];
      tv[5+k].e_id = 2'((k / 3) % 4);
      tv[5+k].chk_data = (k % 3 == 2);
    end

    bus.req_valid = '0;
    bus.req_data = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    step();
    mon_en = 1'b1;

    for (int i = 0; i < 20; i++) begin
      reset = tv[i].rst;
      bus.req_valid = tv[i].rv;
      bus.req_data = tv[i].rd;
      bus.rsp_ready = tv[i].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i),
          32'(bus.req_ready), 32'(tv[i].e_ready));
      chk($sformatf("tbl%0d_valid", i),
          32'(bus.rsp_valid), 32'(tv[i].e_valid));
      chk($sformatf("tbl%0d_busy", i),
          32'(busy), 32'(tv[i].e_busy));
      if (tv[i].chk_data) begin
        chk($sformatf("tbl%0d_data", i),
            32'(bus.rsp_data), 32'(tv[i].e_data));
        chk($sformatf("tbl%0d_id", i),
            32'(bus.rsp_id), 32'(tv[i].e_id));
      end
      step();
    end
    bus.req_valid = '0;
    step();

    // Single request from requester 0.
    do_reset();
    bus.req_data = 32'h000000A5;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_eval_valid", 32'(bus.rsp_valid), 32'h0);
    chk("single_eval_busy", 32'(busy), 32'h1);
    step();
    @(negedge clk);
    chk("single_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_data", 32'(bus.rsp_data), 32'h5A);
    chk("single_id", 32'(bus.rsp_id), 32'h0);
    step();
    @(negedge clk);
    chk("single_busy_fall", 32'(busy), 32'h0);
    step();

    // Response stall with requester 3 waiting.
    do_reset();
    bus.req_data = 32'h773C0000;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("stall_grant2", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("stall_eval_ready", 32'(bus.req_ready), 32'h0);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid), 32'h1);
      chk("stall_data", 32'(bus.rsp_data), 32'hC3);
      chk("stall_id", 32'(bus.rsp_id), 32'h2);
      chk("stall_ready", 32'(bus.req_ready), 32'h0);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(bus.rsp_valid), 32'h1);
    step();
    @(negedge clk);
    chk("stall_grant3", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid = '0;
    step();
    step();
    step();

    // Reset during EVAL abandons the transaction.
    do_reset();
    bus.req_data = 32'h00001100;
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_grant1", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_eval_busy", 32'(busy), 32'h1);
    chk("midrst_ready_rst", 32'(bus.req_ready), 32'h0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst_data", 32'(bus.rsp_data), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    step();
    bus.req_valid = 4'b0011;
    @(negedge clk);
    chk("midrst_ptr0", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    step();
    step();
    step();

    // Pointer wrap and skipping of idle requesters.
    do_reset();
    bus.req_data = 32'h44332211;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("wrap_grant3", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid = '0;
    step();
    step();
    step();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("wrap_grant2", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    step();
    step();
    step();
    bus.req_valid = 4'b0011;
    @(negedge clk);
    chk("wrap_grant0", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    step();
    step();
    step();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
